// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: BIST sequencer for the 32-bit ALU.
// Drives every operand pair from two LFSRs through all 18 ALU commands. The
// DUT ALU and the reference ALU run in parallel, and the sequencer compares
// their five results on every cycle. It counts mismatches and keeps a copy
// of the first failure.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin a run (single-cycle pulse) / stop the current run
//   opA, opB, S, Cin, M   registered drive to both ALUs
//   DO, C, V, N, Z        DUT ALU results
//   *_ref                 reference ALU results
//   busy, done, pass      run status
//   aborted               last run ended by abort
//   err_cnt               saturating mismatch count
//   fail_vec, fail_cmd    vector and command index of the first mismatch
//   fail_obs, fail_exp    {DO,C,V,N,Z} and its reference at the first mismatch
module alu_bist_ctrl #(
  parameter int unsigned n      = 32,
  parameter int unsigned N_VEC  = 1000,
  parameter logic [31:0] SEED_A = 32'h0000_0001,
  parameter logic [31:0] SEED_B = 32'h0000_0002
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic [n-1:0]   opA,
  output logic [n-1:0]   opB,
  output logic [3:0]     S,
  output logic           Cin,
  output logic           M,
  input  logic [n-1:0]   DO,
  input  logic           C,
  input  logic           V,
  input  logic           N,
  input  logic           Z,
  input  logic [n-1:0]   DO_ref,
  input  logic           C_ref,
  input  logic           V_ref,
  input  logic           N_ref,
  input  logic           Z_ref,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           aborted,
  output logic [15:0]    err_cnt,
  output logic [31:0]    fail_vec,
  output logic [4:0]     fail_cmd,
  output logic [n+3:0]   fail_obs,
  output logic [n+3:0]   fail_exp
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SeedA   = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [31:0] SeedB   = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
  localparam logic [31:0] Poly    = 32'h8020_0003;
  localparam logic [4:0]  LastCmd = 5'd17;
  localparam logic [31:0] LastVec = 32'(N_VEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Command ROM, packed as {S,Cin,M}.
  function automatic logic [5:0] cmd_rom(input logic [4:0] idx);
    if (idx < 5'd16)       return {idx[3:0], 2'b10};
    else if (idx == 5'd16) return 6'b100101;
    else                   return 6'b011011;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return (q >> 1) ^ (q[0] ? Poly : 32'd0);
  endfunction

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_lfsr_a, w_lfsr_a_nxt, r_lfsr_b, w_lfsr_b_nxt;
  logic [4:0]    r_cmd_idx, w_cmd_idx_nxt;
  logic [31:0]   r_vec_cnt, w_vec_cnt_nxt;
  logic [n-1:0]  r_op_a, w_op_a_nxt, r_op_b, w_op_b_nxt;
  logic [5:0]    r_cmd, w_cmd_nxt;
  logic          r_aborted, w_aborted_nxt;
  logic [15:0]   r_err_cnt, w_err_cnt_nxt;
  logic          r_fail_seen, w_fail_seen_nxt;
  logic [31:0]   r_fail_vec, w_fail_vec_nxt;
  logic [4:0]    r_fail_cmd, w_fail_cmd_nxt;
  logic [n+3:0]  r_fail_obs, w_fail_obs_nxt, r_fail_exp, w_fail_exp_nxt;

  logic [n+3:0]  w_obs, w_exp;
  logic          w_mismatch;
  logic [31:0]   w_step_a, w_step_b;

  assign w_obs      = {DO, C, V, N, Z};
  assign w_exp      = {DO_ref, C_ref, V_ref, N_ref, Z_ref};
  assign w_mismatch = (w_obs != w_exp);
  assign w_step_a   = lfsr_step(r_lfsr_a);
  assign w_step_b   = lfsr_step(r_lfsr_b);

  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_a_nxt    = r_lfsr_a;
    w_lfsr_b_nxt    = r_lfsr_b;
    w_cmd_idx_nxt   = r_cmd_idx;
    w_vec_cnt_nxt   = r_vec_cnt;
    w_op_a_nxt      = r_op_a;
    w_op_b_nxt      = r_op_b;
    w_cmd_nxt       = r_cmd;
    w_aborted_nxt   = r_aborted;
    w_err_cnt_nxt   = r_err_cnt;
    w_fail_seen_nxt = r_fail_seen;
    w_fail_vec_nxt  = r_fail_vec;
    w_fail_cmd_nxt  = r_fail_cmd;
    w_fail_obs_nxt  = r_fail_obs;
    w_fail_exp_nxt  = r_fail_exp;

    unique case (r_state)
      StIdle, StDone: begin
        // abort is ignored outside RUN, even when it coincides with start.
        if (start) begin
          w_state_nxt     = StRun;
          w_lfsr_a_nxt    = SeedA;
          w_lfsr_b_nxt    = SeedB;
          w_op_a_nxt      = SeedA[n-1:0];
          w_op_b_nxt      = SeedB[n-1:0];
          w_cmd_nxt       = cmd_rom(5'd0);
          w_cmd_idx_nxt   = 5'd0;
          w_vec_cnt_nxt   = 32'd0;
          w_err_cnt_nxt   = 16'd0;
          w_fail_seen_nxt = 1'b0;
          w_fail_vec_nxt  = 32'd0;
          w_fail_cmd_nxt  = 5'd0;
          w_fail_obs_nxt  = '0;
          w_fail_exp_nxt  = '0;
          w_aborted_nxt   = 1'b0;
        end
      end
      StRun: begin
        // The ALUs are combinational: this cycle's results belong to the
        // command currently on the drive registers.
        if (w_mismatch) begin
          if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
          if (!r_fail_seen) begin
            w_fail_seen_nxt = 1'b1;
            w_fail_vec_nxt  = r_vec_cnt;
            w_fail_cmd_nxt  = r_cmd_idx;
            w_fail_obs_nxt  = w_obs;
            w_fail_exp_nxt  = w_exp;
          end
        end
        if (abort) begin
          w_state_nxt   = StDone;
          w_aborted_nxt = 1'b1;
        end else if (r_cmd_idx != LastCmd) begin
          w_cmd_idx_nxt = r_cmd_idx + 5'd1;
          w_cmd_nxt     = cmd_rom(r_cmd_idx + 5'd1);
        end else if (r_vec_cnt != LastVec) begin
          w_lfsr_a_nxt  = w_step_a;
          w_lfsr_b_nxt  = w_step_b;
          w_op_a_nxt    = w_step_a[n-1:0];
          w_op_b_nxt    = w_step_b[n-1:0];
          w_cmd_nxt     = cmd_rom(5'd0);
          w_cmd_idx_nxt = 5'd0;
          w_vec_cnt_nxt = r_vec_cnt + 32'd1;
        end else begin
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_lfsr_a    <= SeedA;
      r_lfsr_b    <= SeedB;
      r_cmd_idx   <= 5'd0;
      r_vec_cnt   <= 32'd0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cmd       <= 6'd0;
      r_aborted   <= 1'b0;
      r_err_cnt   <= 16'd0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= 32'd0;
      r_fail_cmd  <= 5'd0;
      r_fail_obs  <= '0;
      r_fail_exp  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr_a    <= w_lfsr_a_nxt;
      r_lfsr_b    <= w_lfsr_b_nxt;
      r_cmd_idx   <= w_cmd_idx_nxt;
      r_vec_cnt   <= w_vec_cnt_nxt;
      r_op_a      <= w_op_a_nxt;
      r_op_b      <= w_op_b_nxt;
      r_cmd       <= w_cmd_nxt;
      r_aborted   <= w_aborted_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_fail_seen <= w_fail_seen_nxt;
      r_fail_vec  <= w_fail_vec_nxt;
      r_fail_cmd  <= w_fail_cmd_nxt;
      r_fail_obs  <= w_fail_obs_nxt;
      r_fail_exp  <= w_fail_exp_nxt;
    end
  end

  assign opA          = r_op_a;
  assign opB          = r_op_b;
  assign {S, Cin, M}  = r_cmd;
  assign busy         = (r_state == StRun);
  assign done         = (r_state == StDone);
  assign aborted      = r_aborted;
  assign pass         = done & ~r_aborted & (r_err_cnt == 16'd0);
  assign err_cnt      = r_err_cnt;
  assign fail_vec     = r_fail_vec;
  assign fail_cmd     = r_fail_cmd;
  assign fail_obs     = r_fail_obs;
  assign fail_exp     = r_fail_exp;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
module tb_alu_bist_ctrl;

  localparam int SatVec = 3641;  // 18*3641 = 65538 cycles, just past 16'hFFFF

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Mock ALU: any deterministic function of the drive works for the compare.
  function automatic logic [35:0] mock_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] c);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {27'd0, c};
    return {s[31:0], s[32], a[31] ^ b[31], s[31], s[31:0] == 32'd0};
  endfunction

  function automatic logic [31:0] model_lfsr(input logic [31:0] q);
    return (q >> 1) ^ (q[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  // ---------------- DUT u2: N_VEC=2, default seeds ----------------
  logic rst2 = 1'b1, start2 = 1'b0, abort2 = 1'b0;
  logic inj_c = 1'b0, inj_do = 1'b0;
  logic [31:0] opA2, opB2, DO2, DOr2, fail_vec2;
  logic [3:0]  S2;
  logic        Cin2, M2, C2, V2, N2, Z2, Cr2, Vr2, Nr2, Zr2;
  logic        busy2, done2, pass2, aborted2;
  logic [15:0] err_cnt2;
  logic [4:0]  fail_cmd2;
  logic [35:0] fail_obs2, fail_exp2, inj2;

  assign {DO2, C2, V2, N2, Z2} = mock_alu(opA2, opB2, {S2, Cin2, M2});
  assign inj2 = (inj_do ? 36'h10 : 36'h0)
              ^ ((inj_c && opA2 == 32'h8020_0003 && {S2, Cin2, M2} == 6'h25) ? 36'h8 : 36'h0);
  assign {DOr2, Cr2, Vr2, Nr2, Zr2} = {DO2, C2, V2, N2, Z2} ^ inj2;

  alu_bist_ctrl #(.n(32), .N_VEC(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2),
    .opA(opA2), .opB(opB2), .S(S2), .Cin(Cin2), .M(M2),
    .DO(DO2), .C(C2), .V(V2), .N(N2), .Z(Z2),
    .DO_ref(DOr2), .C_ref(Cr2), .V_ref(Vr2), .N_ref(Nr2), .Z_ref(Zr2),
    .busy(busy2), .done(done2), .pass(pass2), .aborted(aborted2), .err_cnt(err_cnt2),
    .fail_vec(fail_vec2), .fail_cmd(fail_cmd2), .fail_obs(fail_obs2), .fail_exp(fail_exp2)
  );

  // ---------------- DUT u4: N_VEC=4, SEED_A=0 ----------------
  logic rst4 = 1'b1, start4 = 1'b0, abort4 = 1'b0;
  logic [31:0] opA4, opB4, DO4, fail_vec4;
  logic [3:0]  S4;
  logic        Cin4, M4, C4, V4, N4, Z4;
  logic        busy4, done4, pass4, aborted4;
  logic [15:0] err_cnt4;
  logic [4:0]  fail_cmd4;
  logic [35:0] fail_obs4, fail_exp4;

  assign {DO4, C4, V4, N4, Z4} = mock_alu(opA4, opB4, {S4, Cin4, M4});

  alu_bist_ctrl #(.n(32), .N_VEC(4), .SEED_A(32'h0)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .abort(abort4),
    .opA(opA4), .opB(opB4), .S(S4), .Cin(Cin4), .M(M4),
    .DO(DO4), .C(C4), .V(V4), .N(N4), .Z(Z4),
    .DO_ref(DO4), .C_ref(C4), .V_ref(V4), .N_ref(N4), .Z_ref(Z4),
    .busy(busy4), .done(done4), .pass(pass4), .aborted(aborted4), .err_cnt(err_cnt4),
    .fail_vec(fail_vec4), .fail_cmd(fail_cmd4), .fail_obs(fail_obs4), .fail_exp(fail_exp4)
  );

  // ---------------- DUT us: saturation, persistent mismatch ----------------
  logic rsts = 1'b1, starts = 1'b0, aborts = 1'b0;
  logic [31:0] opAs, opBs, DOs, fail_vecs;
  logic [3:0]  Ss;
  logic        Cins, Ms, Cs, Vs, Ns, Zs;
  logic        busys, dones, passs, aborteds;
  logic [15:0] err_cnts;
  logic [4:0]  fail_cmds;
  logic [35:0] fail_obss, fail_exps;

  assign {DOs, Cs, Vs, Ns, Zs} = mock_alu(opAs, opBs, {Ss, Cins, Ms});

  alu_bist_ctrl #(.n(32), .N_VEC(SatVec)) u_duts (
    .clk(clk), .rst(rsts), .start(starts), .abort(aborts),
    .opA(opAs), .opB(opBs), .S(Ss), .Cin(Cins), .M(Ms),
    .DO(DOs), .C(Cs), .V(Vs), .N(Ns), .Z(Zs),
    .DO_ref(DOs ^ 32'd1), .C_ref(Cs), .V_ref(Vs), .N_ref(Ns), .Z_ref(Zs),
    .busy(busys), .done(dones), .pass(passs), .aborted(aborteds), .err_cnt(err_cnts),
    .fail_vec(fail_vecs), .fail_cmd(fail_cmds), .fail_obs(fail_obss), .fail_exp(fail_exps)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst2 = 1'b1; rst4 = 1'b1; rsts = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0; rst4 = 1'b0; rsts = 1'b0;
    n_vec++;
    if ({opA2, opB2, S2, Cin2, M2, busy2, done2, pass2, aborted2, err_cnt2} !== 91'd0) begin
      n_bad++;
      $display("FAIL reset_drive: got opA=%h opB=%h cmd=%h busy=%b done=%b pass=%b ab=%b err=%h, want all 0",
               opA2, opB2, {S2, Cin2, M2}, busy2, done2, pass2, aborted2, err_cnt2);
    end
    n_vec++;
    if ({fail_vec2, fail_cmd2, fail_obs2, fail_exp2} !== 109'd0) begin
      n_bad++;
      $display("FAIL reset_fail_regs: got vec=%h cmd=%h obs=%h exp=%h, want all 0",
               fail_vec2, fail_cmd2, fail_obs2, fail_exp2);
    end
  endtask

  // Starts u2 and checks the drive sequence of a full 2-vector run cycle by cycle.
  task automatic run2_sweep(input string tag);
    logic [31:0] ea, eb;
    logic [5:0]  ec;
    logic [4:0]  k;
    int cyc, idx;
    ea = 32'd1; eb = 32'd2; cyc = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (busy2 && cyc < 200) begin
      idx = cyc % 18;
      if (idx == 0 && cyc != 0) begin ea = model_lfsr(ea); eb = model_lfsr(eb); end
      k  = 5'(idx);
      ec = (idx < 16) ? {k[3:0], 2'b10} : ((idx == 16) ? 6'h25 : 6'h1B);
      n_vec++;
      if ({S2, Cin2, M2, opA2, opB2} !== {ec, ea, eb}) begin
        n_bad++;
        $display("FAIL %s drive cyc %0d: got cmd=%h opA=%h opB=%h, want cmd=%h opA=%h opB=%h",
                 tag, cyc, {S2, Cin2, M2}, opA2, opB2, ec, ea, eb);
      end
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    if (cyc !== 36) begin
      n_bad++;
      $display("FAIL %s busy_len: got %0d cycles, want 36", tag, cyc);
    end
    n_vec++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_flag: got done=%b busy=%b, want done=1 busy=0", tag, done2, busy2);
    end
  endtask

  task automatic test_sweep_clean();
    run2_sweep("clean");
    n_vec++;
    if ({pass2, aborted2, err_cnt2} !== {1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL clean_result: got pass=%b ab=%b err=%0d, want pass=1 ab=0 err=0",
               pass2, aborted2, err_cnt2);
    end
  endtask

  task automatic test_single_fault();
    inj_c = 1'b1;
    run2_sweep("cfault");
    inj_c = 1'b0;
    n_vec++;
    if ({err_cnt2, fail_vec2, fail_cmd2, pass2} !== {16'd1, 32'd1, 5'd16, 1'b0}) begin
      n_bad++;
      $display("FAIL cfault_capture: got err=%0d vec=%0d cmd=%0d pass=%b, want err=1 vec=1 cmd=16 pass=0",
               err_cnt2, fail_vec2, fail_cmd2, pass2);
    end
    n_vec++;
    if ((fail_obs2 ^ fail_exp2) !== 36'h8) begin
      n_bad++;
      $display("FAIL cfault_bits: got obs^exp=%h, want 000000008", fail_obs2 ^ fail_exp2);
    end
  endtask

  task automatic test_all_fault();
    inj_do = 1'b1;
    run2_sweep("dofault");
    inj_do = 1'b0;
    n_vec++;
    if ({err_cnt2, fail_vec2, fail_cmd2, pass2} !== {16'd36, 32'd0, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL dofault_capture: got err=%0d vec=%0d cmd=%0d pass=%b, want err=36 vec=0 cmd=0 pass=0",
               err_cnt2, fail_vec2, fail_cmd2, pass2);
    end
    n_vec++;
    if ((fail_obs2 ^ fail_exp2) !== 36'h10) begin
      n_bad++;
      $display("FAIL dofault_bits: got obs^exp=%h, want 000000010", fail_obs2 ^ fail_exp2);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (10) @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    n_vec++;
    if ({opA2, opB2, S2, Cin2, M2, busy2, done2, pass2, aborted2, err_cnt2, fail_vec2,
         fail_cmd2, fail_obs2, fail_exp2} !== 200'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got opA=%h cmd=%h busy=%b done=%b err=%h, want all 0",
               opA2, {S2, Cin2, M2}, busy2, done2, err_cnt2);
    end
    run2_sweep("after_rst");
  endtask

  task automatic test_start_ignored();
    int cyc;
    // start and abort together from IDLE: the run starts, abort is dropped.
    @(negedge clk); start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk); start4 = 1'b0; abort4 = 1'b0;
    n_vec++;
    if ({busy4, opA4, opB4} !== {1'b1, 32'd1, 32'd2}) begin
      n_bad++;
      $display("FAIL seed0_first: got busy=%b opA=%h opB=%h, want busy=1 opA=1 opB=2",
               busy4, opA4, opB4);
    end
    cyc = 0;
    while (busy4 && cyc < 300) begin
      start4 = (cyc == 3);
      cyc++;
      @(negedge clk);
    end
    start4 = 1'b0;
    n_vec++;
    if (cyc !== 72) begin
      n_bad++;
      $display("FAIL restart_ignored_len: got %0d cycles, want 72", cyc);
    end
    n_vec++;
    if ({done4, pass4, aborted4} !== 3'b110) begin
      n_bad++;
      $display("FAIL restart_ignored_end: got done=%b pass=%b ab=%b, want 1 1 0",
               done4, pass4, aborted4);
    end
  endtask

  task automatic test_abort();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (20) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    n_vec++;
    if ({done4, busy4, aborted4, pass4} !== 4'b1010) begin
      n_bad++;
      $display("FAIL abort_flags: got done=%b busy=%b ab=%b pass=%b, want 1 0 1 0",
               done4, busy4, aborted4, pass4);
    end
    // Cycle 20 is vec 1, cmd 2; the drive freezes there.
    n_vec++;
    if ({opA4, S4, Cin4, M4} !== {32'h8020_0003, 6'h0A}) begin
      n_bad++;
      $display("FAIL abort_frozen: got opA=%h cmd=%h, want opA=80200003 cmd=0a",
               opA4, {S4, Cin4, M4});
    end
    abort4 = 1'b1;
    repeat (3) @(negedge clk);
    abort4 = 1'b0;
    n_vec++;
    if ({done4, aborted4, opA4, S4, Cin4, M4} !== {2'b11, 32'h8020_0003, 6'h0A}) begin
      n_bad++;
      $display("FAIL done_hold: got done=%b ab=%b opA=%h cmd=%h, want 1 1 80200003 0a",
               done4, aborted4, opA4, {S4, Cin4, M4});
    end
  endtask

  task automatic test_saturation();
    int cyc;
    @(negedge clk); starts = 1'b1;
    @(negedge clk); starts = 1'b0;
    cyc = 0;
    while (busys && cyc < 70000) begin
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    if (cyc !== 18 * SatVec) begin
      n_bad++;
      $display("FAIL sat_len: got %0d cycles, want %0d", cyc, 18 * SatVec);
    end
    n_vec++;
    if ({err_cnts, fail_vecs, fail_cmds, passs} !== {16'hFFFF, 32'd0, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL sat_count: got err=%h vec=%0d cmd=%0d pass=%b, want ffff 0 0 0",
               err_cnts, fail_vecs, fail_cmds, passs);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_clean();
    test_single_fault();
    test_all_fault();
    test_reset_mid_run();
    test_start_ignored();
    test_abort();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
